// File: rtl/uart_cmd_rx_if.sv
// Configuration-write bus driven by the UART command receiver.
//   wr_en   : one-cycle pulse marking a valid configuration write
//   wr_ch   : target channel index (valid while wr_en is high, held otherwise)
//   wr_addr : target register address (valid while wr_en is high, held otherwise)
//   wr_data : write payload (valid while wr_en is high, held otherwise)
//   err     : one-cycle pulse on framing, checksum, channel-range or timeout error
//   busy    : high while the frame parser is outside IDLE
// master = receiver side (drives everything), slave = consumer side.
interface uart_cmd_rx_if;
  logic        wr_en;
  logic [3:0]  wr_ch;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic        busy;

  modport master (output wr_en, wr_ch, wr_addr, wr_data, err, busy);
  modport slave  (input  wr_en, wr_ch, wr_addr, wr_data, err, busy);
endinterface

// File: rtl/uart_cmd_rx.sv
// UART (8N1) command receiver: turns framed serial commands into
// configuration-register writes.
// Frame: A5 | CMD | D0 D1 D2 D3 | CHK, CMD = {channel, address},
// data little-endian, CHK = XOR of CMD and D0..D3.
// Ports:
//   i_clk : system clock, all registers on its rising edge
//   _rst  : asynchronous active-low reset
//   rx    : asynchronous UART line, idle high
//   bus   : write/err/busy outputs (uart_cmd_rx_if.master)
//
// Parser states
//   state  | meaning
//   P_IDLE | hunting for the 0xA5 sync byte, other bytes dropped silently
//   P_CMD  | next byte is CMD (channel/address)
//   P_DATA | collecting D0..D3, byte_idx counts 0..3
//   P_CHK  | next byte is the checksum, write or error decided here
module uart_cmd_rx #(
  parameter int CH_NO          = 4,
  parameter int BAUD_PRESCALER = 434,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic          i_clk,
  input  logic          _rst,
  input  logic          rx,
  uart_cmd_rx_if.master bus
);

  localparam int BW = $clog2(BAUD_PRESCALER);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [BW-1:0] BIT_LOAD  = BW'(BAUD_PRESCALER - 1);
  localparam logic [BW-1:0] HALF_LOAD = BW'(BAUD_PRESCALER / 2 - 1);
  localparam logic [TW-1:0] TMO_LOAD  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [4:0]    CH_LIM    = 5'(CH_NO);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_IDLE, P_CMD, P_DATA, P_CHK} p_state_t;

  // ---------------- synchroniser + byte receiver ----------------
  logic          rx_meta, rx_sync, rx_prev;
  logic [1:0]    sync_fill;  // marks when rx_sync carries a real line sample
  logic          armed;      // line seen high since reset
  rx_state_t     r_state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          byte_valid, frame_err;
  logic [7:0]    rx_byte;

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      sync_fill  <= 2'b00;
      armed      <= 1'b0;
      r_state    <= R_IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      rx_byte    <= '0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      sync_fill  <= {sync_fill[0], 1'b1};
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // The reset value of the synchroniser is not a real line level, so a
      // start edge is only honoured once the line itself has been seen high.
      if (sync_fill[1] && rx_sync) armed <= 1'b1;
      case (r_state)
        R_IDLE: begin
          if (armed && rx_prev && !rx_sync) begin
            r_state  <= R_START;
            baud_cnt <= HALF_LOAD;
          end
        end
        R_START: begin
          if (baud_cnt == '0) begin
            // still low at mid start bit: real start; otherwise a glitch
            r_state  <= rx_sync ? R_IDLE : R_DATA;
            baud_cnt <= BIT_LOAD;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        R_DATA: begin
          if (baud_cnt == '0) begin
            shift_q  <= {rx_sync, shift_q[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            baud_cnt <= BIT_LOAD;
            if (bit_idx == 3'd7) r_state <= R_STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        R_STOP: begin
          if (baud_cnt == '0) begin
            r_state <= R_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= shift_q;
            end else begin
              frame_err <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // ---------------- frame parser ----------------
  p_state_t      p_state;
  logic [1:0]    byte_idx;
  logic [7:0]    cmd_q;
  logic [7:0]    chk_acc;
  logic [31:0]   data_q;
  logic [TW-1:0] tmo_cnt;

  always_ff @(posedge i_clk or negedge _rst) begin
    if (!_rst) begin
      p_state     <= P_IDLE;
      byte_idx    <= '0;
      cmd_q       <= '0;
      chk_acc     <= '0;
      data_q      <= '0;
      tmo_cnt     <= '0;
      bus.wr_en   <= 1'b0;
      bus.wr_ch   <= '0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      bus.err     <= 1'b0;
      bus.busy    <= 1'b0;
    end else begin
      bus.wr_en <= 1'b0;
      bus.err   <= 1'b0;
      if (frame_err) begin
        // takes priority over a coincident timeout: a single err pulse
        p_state  <= P_IDLE;
        bus.busy <= 1'b0;
        bus.err  <= 1'b1;
      end else if (byte_valid) begin
        tmo_cnt <= TMO_LOAD;
        case (p_state)
          P_IDLE: begin
            if (rx_byte == 8'hA5) begin
              p_state  <= P_CMD;
              bus.busy <= 1'b1;
            end
          end
          P_CMD: begin
            cmd_q    <= rx_byte;
            chk_acc  <= rx_byte;
            byte_idx <= '0;
            p_state  <= P_DATA;
          end
          P_DATA: begin
            data_q   <= {rx_byte, data_q[31:8]};
            chk_acc  <= chk_acc ^ rx_byte;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) p_state <= P_CHK;
          end
          P_CHK: begin
            p_state  <= P_IDLE;
            bus.busy <= 1'b0;
            if (rx_byte == chk_acc && {1'b0, cmd_q[7:4]} < CH_LIM) begin
              bus.wr_en   <= 1'b1;
              bus.wr_ch   <= cmd_q[7:4];
              bus.wr_addr <= cmd_q[3:0];
              bus.wr_data <= data_q;
            end else begin
              bus.err <= 1'b1;
            end
          end
          default: p_state <= P_IDLE;
        endcase
      end else if (p_state != P_IDLE) begin
        if (tmo_cnt == '0) begin
          p_state  <= P_IDLE;
          bus.busy <= 1'b0;
          bus.err  <= 1'b1;
        end else begin
          tmo_cnt <= tmo_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
module tb_uart_cmd_rx;
  localparam int BAUD = 8;
  localparam int TMO  = 400;

  logic i_clk = 1'b0;
  logic rst_l = 1'b0;
  logic rx    = 1'b1;

  uart_cmd_rx_if bus ();

  uart_cmd_rx #(.CH_NO(4), .BAUD_PRESCALER(BAUD), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk (i_clk),
    ._rst  (rst_l),
    .rx    (rx),
    .bus   (bus.master)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;
  int wr_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  int err_cyc = 0;

  always @(negedge i_clk) begin
    cyc++;
    if (bus.wr_en) wr_cnt++;
    if (bus.err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge i_clk);
    rx = 1'b0;
    repeat (BAUD) @(negedge i_clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge i_clk);
    end
    rx = stop;
    repeat (BAUD) @(negedge i_clk);
    rx = 1'b1;
  endtask

  typedef struct packed {
    logic [71:0] bytes;  // byte i at [8*i +: 8]
    logic [3:0]  n;
    logic [1:0]  wr;
    logic [1:0]  er;
    logic [3:0]  ch;
    logic [3:0]  addr;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int w0, e0, ok;
    logic [7:0] bv;

    vecs[0] = '{72'h00_00_1A_12_34_56_78_12_A5, 4'd7, 2'd1, 2'd0, 4'h1, 4'h2, 32'h12345678};
    vecs[1] = '{72'h00_00_1B_12_34_56_78_12_A5, 4'd7, 2'd0, 2'd1, 4'h1, 4'h2, 32'h12345678};
    vecs[2] = '{72'h00_00_1A_12_34_56_78_12_A5, 4'd7, 2'd1, 2'd0, 4'h1, 4'h2, 32'h12345678};
    vecs[3] = '{72'h00_00_52_00_00_00_00_52_A5, 4'd7, 2'd0, 2'd1, 4'h1, 4'h2, 32'h12345678};
    vecs[4] = '{72'h00_00_40_00_00_00_00_40_A5, 4'd7, 2'd0, 2'd1, 4'h1, 4'h2, 32'h12345678};
    vecs[5] = '{72'h00_00_31_A5_A5_A5_A5_31_A5, 4'd7, 2'd1, 2'd0, 4'h3, 4'h1, 32'hA5A5A5A5};
    vecs[6] = '{72'h23_DE_AD_BE_EF_01_A5_00_33, 4'd9, 2'd1, 2'd0, 4'h0, 4'h1, 32'hDEADBEEF};
    vecs[7] = '{72'h00_00_47_44_33_22_11_03_A5, 4'd7, 2'd1, 2'd0, 4'h0, 4'h3, 32'h44332211};

    // reset state
    repeat (3) @(negedge i_clk);
    check("reset_outputs", {22'd0, bus.wr_en, bus.err, bus.busy, bus.wr_ch, bus.wr_addr}, 32'd0);
    check("reset_wr_data", bus.wr_data, 32'd0);
    rst_l = 1'b1;
    repeat (10) @(negedge i_clk);

    // table-driven frames
    for (int v = 0; v < 8; v++) begin
      w0 = wr_cnt;
      e0 = err_cnt;
      for (int i = 0; i < int'(vecs[v].n); i++) begin
        bv = vecs[v].bytes[8*i +: 8];
        send_byte(bv, 1'b1);
      end
      repeat (40) @(negedge i_clk);
      check($sformatf("v%0d_wr_pulses", v), wr_cnt - w0, 32'(vecs[v].wr));
      check($sformatf("v%0d_err_pulses", v), err_cnt - e0, 32'(vecs[v].er));
      check($sformatf("v%0d_busy", v), bus.busy, 1'b0);
      check($sformatf("v%0d_ch_addr", v), {bus.wr_ch, bus.wr_addr}, {vecs[v].ch, vecs[v].addr});
      check($sformatf("v%0d_data", v), bus.wr_data, vecs[v].data);
    end

    // inter-byte timeout
    e0 = err_cnt;
    w0 = wr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b1);
    begin
      int t_end;
      t_end = cyc;
      repeat (100) @(negedge i_clk);
      check("tmo_busy_waiting", bus.busy, 1'b1);
      for (int k = 0; k < 600 && err_cnt == e0; k++) @(negedge i_clk);
      check("tmo_err_seen", err_cnt - e0, 32'd1);
      ok = (err_cyc - t_end >= 380 && err_cyc - t_end <= 420) ? 1 : 0;
      check("tmo_latency_window", 32'(ok), 32'd1);
      repeat (200) @(negedge i_clk);
      check("tmo_single_err", err_cnt - e0, 32'd1);
      check("tmo_busy_after", bus.busy, 1'b0);
      check("tmo_no_wr", wr_cnt - w0, 32'd0);
    end

    // glitch, then framing error mid-frame
    e0 = err_cnt;
    w0 = wr_cnt;
    rx = 1'b0;
    repeat (2) @(negedge i_clk);
    rx = 1'b1;
    repeat (60) @(negedge i_clk);
    check("glitch_no_err", err_cnt - e0, 32'd0);
    check("glitch_not_busy", bus.busy, 1'b0);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h12, 1'b0);
    repeat (20) @(negedge i_clk);
    check("stop_err", err_cnt - e0, 32'd1);
    check("stop_parser_idle", bus.busy, 1'b0);
    check("stop_no_wr", wr_cnt - w0, 32'd0);

    // reset mid-frame, line held low across release
    e0 = err_cnt;
    w0 = wr_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    @(negedge i_clk);
    rx = 1'b0;
    repeat (20) @(negedge i_clk);
    rst_l = 1'b0;
    #2;
    check("rst_mid_outputs", {22'd0, bus.wr_en, bus.err, bus.busy, bus.wr_ch, bus.wr_addr}, 32'd0);
    check("rst_mid_wr_data", bus.wr_data, 32'd0);
    repeat (5) @(negedge i_clk);
    rst_l = 1'b1;
    repeat (120) @(negedge i_clk);
    rx = 1'b1;
    repeat (50) @(negedge i_clk);
    check("rst_no_err", err_cnt - e0, 32'd0);
    check("rst_no_wr", wr_cnt - w0, 32'd0);
    check("rst_low_line_not_busy", bus.busy, 1'b0);

    // recovery: good frame after reset
    w0 = wr_cnt;
    for (int i = 0; i < 7; i++) begin
      bv = vecs[0].bytes[8*i +: 8];
      send_byte(bv, 1'b1);
    end
    repeat (40) @(negedge i_clk);
    check("post_rst_wr", wr_cnt - w0, 32'd1);
    check("post_rst_data", bus.wr_data, 32'h12345678);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_cmd_rx.md
UART_CMD_RX -- requirements
Module: uart_cmd_rx

Interface
REQ-001: Parameter CH_NO, default 4, number of addressable capture channels (1..16).
REQ-002: Parameter BAUD_PRESCALER, default 434, i_clk cycles per UART bit (minimum 4).
REQ-003: Parameter TIMEOUT_CYCLES, default 50000, maximum idle gap between bytes inside a frame.
REQ-004: i_clk  input  1  single clock; every register SHALL be clocked on its rising edge.
REQ-005: _rst  input  1  asynchronous, active-low reset.
REQ-006: rx  input  1  asynchronous UART line, 8N1, idle high.
REQ-007: wr_en  output  1  one-cycle pulse marking a valid configuration write.
REQ-008: wr_ch  output  4  target channel index, valid while wr_en is high.
REQ-009: wr_addr  output  4  target register address, valid while wr_en is high.
REQ-010: wr_data  output  32  write payload, valid while wr_en is high.
REQ-011: err  output  1  one-cycle pulse on framing, checksum, channel-range or timeout error.
REQ-012: busy  output  1  high while the parser is outside IDLE.

Function
REQ-013: rx SHALL pass through a 2-flop synchroniser, reset to 1; all logic SHALL use only the synchronised value.
REQ-014: Byte receiver SHALL detect start on a synchronised high-to-low transition, recheck low after BAUD_PRESCALER/2 cycles, and return to idle with no error if the line is high (glitch).
REQ-015: Data bits SHALL be sampled every BAUD_PRESCALER cycles after the start-bit midpoint, LSB first.
REQ-016: The stop-bit sample SHALL produce an internal byte_valid pulse; a low stop bit SHALL discard the byte, pulse err, and force the parser to IDLE.
REQ-017: Frame format: 0xA5 sync, CMD, D0..D3 (little-endian, D0 = wr_data[7:0]), CHK; wr_ch = CMD[7:4], wr_addr = CMD[3:0].
REQ-018: CHK SHALL equal the 8-bit XOR of CMD, D0, D1, D2 and D3.
REQ-019: Parser states SHALL be IDLE, CMD, DATA (2-bit byte counter 0..3), CHK.
REQ-020: In IDLE, any byte other than 0xA5 SHALL be ignored silently; 0xA5 SHALL move to CMD.
REQ-021: CMD -> DATA on any byte; DATA -> CHK after the 4th data byte; CHK -> IDLE on any byte.
REQ-022: In CHK, on checksum match and wr_ch < CH_NO, wr_en SHALL pulse exactly one cycle, the cycle after byte_valid.
REQ-023: In CHK, on checksum mismatch or wr_ch >= CH_NO, err SHALL pulse in that same cycle and wr_en SHALL stay low.
REQ-024: wr_ch, wr_addr and wr_data SHALL hold their last value between pulses and SHALL never change while wr_en is high.
REQ-025: Outside IDLE, TIMEOUT_CYCLES cycles with no byte_valid SHALL force IDLE and pulse err once; the counter SHALL clear on each byte_valid.
REQ-026: A 0xA5 received in CMD, DATA or CHK SHALL be treated as an ordinary byte, with no resynchronisation.
REQ-027: If a framing error and a timeout occur in the same cycle, err SHALL pulse for one cycle only.
REQ-028: busy SHALL be high in CMD, DATA and CHK, and low in IDLE.

Reset
REQ-029: Asserting _rst low SHALL immediately set: parser IDLE, receiver idle, counters 0, synchroniser flops 1, wr_en 0, err 0, busy 0, wr_ch 0, wr_addr 0, wr_data 0.
REQ-030: Reset asserted mid-byte or mid-frame SHALL abandon the partial frame with no wr_en and no err pulse.
REQ-031: After _rst releases, the receiver SHALL require rx high for at least one cycle before accepting a start edge.

Verification (BAUD_PRESCALER=8, TIMEOUT_CYCLES=400)
REQ-032: Send A5 12 78 56 34 12 1A -> one wr_en pulse with wr_ch=1, wr_addr=2, wr_data=0x12345678, err never high.
REQ-033: Same frame with CHK=1B -> no wr_en, one err pulse, busy low afterwards; the next good frame is accepted.
REQ-034: Send A5 52 00 00 00 00 52 with CH_NO=4 -> no wr_en, one err pulse (channel out of range).
REQ-035: Send A5 12, then idle 500 cycles -> one err pulse about 400 cycles after the CMD byte, parser back in IDLE.
REQ-036: Send 33 00 A5 01 EF BE AD DE CHK, with correct XOR 0x01^0xEF^0xBE^0xAD^0xDE -> leading bytes ignored, wr_data=0xDEADBEEF, wr_ch=0, wr_addr=1.
REQ-037: Send a 2-cycle low glitch on rx, then a byte with a low stop bit, then pull _rst low mid-frame -> glitch ignored, err on the stop bit, all outputs zero during reset.
